full_mat_seq: RTL and testbench
===============================

Name: full_mat_seq

Overview:
- Frame sequencer for the full-Jacobian matrix datapath.
- Accepts a start request and runs the 91-cycle frame counter for a requested number of frames.
- Generates the shared enable, the delayed mat_mult reset pulse and the array_mult reset.
- Drains the multiplier pipelines after the last frame, then pulses done.
- Replaces the free-running count/rst logic currently hand-built in the full_mat testbench top.

Parameters:
FRAME_LEN, 91, cycles per frame; count wraps FRAME_LEN-1 -> 0
CNT_W, 8, width of count
MM_RST_AT, 4, count value whose enabled cycle causes mat_mult_rst high on the next enabled cycle
FRAMES_W, 4, width of num_frames and frame_idx
DRAIN_LEN, 8, enabled cycles after the last frame before done

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-low (0 = reset)
start  in  1  request to begin a run
ready  out  1  block can accept start
num_frames  in  FRAMES_W  frames to run, sampled on accept
hold  in  1  stall; freezes all sequencing while high
en  out  1  datapath enable to full_mat, mat_mult and array_mult
count  out  CNT_W  position within the current frame
frame_idx  out  FRAMES_W  index of the current frame
frame_start  out  1  high on the enabled cycle where count==0 in RUN
mat_mult_rst  out  1  reset to mat_mult
array_mult_rst  out  1  reset to array_mult
busy  out  1  high in RUN or DRAIN
done  out  1  single-cycle completion pulse

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; count=0, frame_idx=0, drain counter=0, latched frame total=0.
  - Registered outputs: mat_mult_rst=1, done=0.
  - Derived outputs after reset: ready=1, busy=0, en=0, array_mult_rst=1, frame_start=0.
  - Reset wins over every other input, including mid-run; no done is issued.
- States:
  - IDLE: ready=1, en=0, busy=0, mat_mult_rst=1, array_mult_rst=1.
    - start=1 with num_frames!=0 latches num_frames and moves to RUN with count=0, frame_idx=0.
    - start=1 with num_frames==0 is ignored; state stays IDLE, no done.
    - hold has no effect.
  - RUN: busy=1, array_mult_rst=0, en = ~hold (combinational).
    - On each posedge with en=1: count increments.
    - At count==FRAME_LEN-1, count wraps to 0 and frame_idx increments.
    - If that wrap ends frame latched-1: frame_idx holds its value, count goes to 0 and the state moves to DRAIN.
  - DRAIN: busy=1, en = ~hold, count held at 0.
    - Drain counter increments on each enabled cycle.
    - After DRAIN_LEN enabled cycles the state moves to DONE.
  - DONE: one cycle only; done=1, en=0, busy=0, ready=0. Next state is IDLE.
- mat_mult_rst register:
  - In RUN, updates only on enabled cycles: next value = (count==MM_RST_AT).
  - The pulse is high for exactly one enabled cycle per frame, the enabled cycle after count==MM_RST_AT.
  - Forced to 1 in IDLE.
  - In DRAIN and DONE it holds at 0.
- frame_start = en & (state==RUN) & (count==0); combinational.
- hold:
  - Freezes count, frame_idx, drain counter, mat_mult_rst and state.
  - A wrap or drain-end that coincides with hold=1 is deferred until the first cycle with hold=0.
- start while busy or in DONE is ignored and not queued.
- count never exceeds FRAME_LEN-1; frame_idx never exceeds latched-1.
- Latency, no holds: a run is accepted at edge E0.
  - RUN lasts num_frames*FRAME_LEN cycles.
  - DRAIN lasts DRAIN_LEN cycles.
  - done is high during cycle num_frames*FRAME_LEN + DRAIN_LEN after E0.
  - ready returns one cycle later.

Test Plan:
- Single frame: num_frames=1, start one cycle, hold=0.
  - en high for 91+8=99 cycles.
  - count runs 0..90 then holds 0.
  - mat_mult_rst high exactly one cycle, while count==5.
  - done pulses at cycle 99 after accept; ready=1 on the next cycle.
- Three frames: num_frames=3.
  - frame_start pulses at count==0 of each frame: 3 pulses, spaced 91 cycles apart.
  - frame_idx steps 0,1,2.
  - mat_mult_rst pulses 3 times, each while count==5.
  - done pulses at cycle 3*91+8=281.
- Hold mid-frame: hold=1 for 10 cycles at count==40 of frame 0.
  - en=0, count stays 40, mat_mult_rst unchanged.
  - done is delayed by exactly 10 cycles.
  - Also assert hold on the count==90 cycle and check the wrap waits for hold=0.
- Zero/ignored starts:
  - num_frames=0 with start: ready stays 1, en stays 0, no done.
  - start pulsed during RUN of a 2-frame job: no restart, done once at 2*91+8=190.
- Reset mid-run: rst=0 at count==50 of frame 1.
  - Next cycle: IDLE, count=0, frame_idx=0, en=0, mat_mult_rst=1, array_mult_rst=1, no done.
  - A new start is then accepted normally.
- Back-to-back runs: start held high continuously with num_frames=1.
  - A second run is accepted on the cycle after done (the first IDLE cycle).
  - Exactly 2 done pulses with a 1-cycle IDLE gap between runs.

Source files
------------

// File: rtl/full_mat_seq_if.sv
// Control/status bundle between the full_mat frame sequencer and whoever
// launches runs (testbench top or host controller).
interface full_mat_seq_if #(
    parameter int CNT_W    = 8,
    parameter int FRAMES_W = 4
);
    logic                start;
    logic                ready;
    logic [FRAMES_W-1:0] num_frames;
    logic                hold;
    logic                en;
    logic [CNT_W-1:0]    count;
    logic [FRAMES_W-1:0] frame_idx;
    logic                frame_start;
    logic                mat_mult_rst;
    logic                array_mult_rst;
    logic                busy;
    logic                done;

    modport master (
        output start, num_frames, hold,
        input  ready, en, count, frame_idx, frame_start,
               mat_mult_rst, array_mult_rst, busy, done
    );

    modport slave (
        input  start, num_frames, hold,
        output ready, en, count, frame_idx, frame_start,
               mat_mult_rst, array_mult_rst, busy, done
    );
endinterface

// File: rtl/full_mat_seq.sv
// Frame sequencer for the full-Jacobian matrix datapath: runs N frames of
// FRAME_LEN cycles, drains the multiplier pipelines, then pulses done.
module full_mat_seq #(
    parameter int FRAME_LEN = 91,
    parameter int CNT_W     = 8,
    parameter int MM_RST_AT = 4,
    parameter int FRAMES_W  = 4,
    parameter int DRAIN_LEN = 8
) (
    input  logic             clk,
    input  logic             rst,
    full_mat_seq_if.slave    bus
);
    localparam int DRN_W = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MM   = CNT_W'(MM_RST_AT);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    count, count_nx;
    logic [FRAMES_W-1:0] frame_idx, frame_nx;
    logic [FRAMES_W-1:0] frames_lat, frames_nx;
    logic [DRN_W-1:0]    drain_cnt, drain_nx;
    logic                mm_rst, mm_rst_nx;
    logic                done_q;
    logic                en_c;

    assign en_c = ((state == RUN) || (state == DRAIN)) && !bus.hold;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= '0;
            frame_idx  <= '0;
            frames_lat <= '0;
            drain_cnt  <= '0;
            mm_rst     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            frame_idx  <= frame_nx;
            frames_lat <= frames_nx;
            drain_cnt  <= drain_nx;
            mm_rst     <= mm_rst_nx;
            done_q     <= (state_nx == DONE);
        end
    end

    always_comb begin
        state_nx  = state;
        count_nx  = count;
        frame_nx  = frame_idx;
        frames_nx = frames_lat;
        drain_nx  = drain_cnt;
        mm_rst_nx = mm_rst;
        case (state)
            IDLE: begin
                // mat_mult stays in reset until a run is accepted
                if (bus.start && (bus.num_frames != '0)) begin
                    state_nx  = RUN;
                    count_nx  = '0;
                    frame_nx  = '0;
                    frames_nx = bus.num_frames;
                    mm_rst_nx = 1'b0;
                end else begin
                    mm_rst_nx = 1'b1;
                end
            end
            RUN: begin
                if (en_c) begin
                    mm_rst_nx = (count == CNT_MM);
                    if (count == CNT_LAST) begin
                        count_nx = '0;
                        if (frame_idx == frames_lat - 1'b1) begin
                            state_nx = DRAIN;
                            drain_nx = '0;
                        end else begin
                            frame_nx = frame_idx + 1'b1;
                        end
                    end else begin
                        count_nx = count + 1'b1;
                    end
                end
            end
            DRAIN: begin
                mm_rst_nx = 1'b0;
                if (en_c) begin
                    if (drain_cnt == DRN_LAST) begin
                        state_nx = DONE;
                    end else begin
                        drain_nx = drain_cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                // register reloads to 1 so IDLE starts with mat_mult in reset
                state_nx  = IDLE;
                mm_rst_nx = 1'b1;
                frame_nx  = '0;
                drain_nx  = '0;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.ready          = (state == IDLE);
    assign bus.busy           = (state == RUN) || (state == DRAIN);
    assign bus.en             = en_c;
    assign bus.count          = count;
    assign bus.frame_idx      = frame_idx;
    assign bus.frame_start    = en_c && (state == RUN) && (count == '0);
    assign bus.mat_mult_rst   = mm_rst;
    assign bus.array_mult_rst = !((state == RUN) || (state == DRAIN));
    assign bus.done           = done_q;
endmodule

// File: tb/tb_full_mat_seq.sv
// Directed bench for full_mat_seq: single/multi-frame runs, hold, ignored
// starts, mid-run reset and back-to-back runs.
module tb_full_mat_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    full_mat_seq_if #(.CNT_W(8), .FRAMES_W(4)) bus();

    full_mat_seq #(
        .FRAME_LEN(91), .CNT_W(8), .MM_RST_AT(4), .FRAMES_W(4), .DRAIN_LEN(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // statistics gathered by run_job
    int en_cnt, mm_cnt, mm_bad, fs_n, done_cyc, done_n, freeze_bad, en_bad;
    int max_cnt, max_fidx, ready_after;
    int fs_cyc [4];
    int fs_fidx[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts a job of n frames, then observes max_cyc cycles (cycle 0 is the
    // first cycle after the accept edge). Hold windows and an optional stray
    // start pulse are applied by cycle number.
    task automatic run_job(input int n, input int max_cyc, input int hs1, input int hl1,
                           input int hs2, input int hl2, input int sp_at);
        int  prev_cnt;
        int  prev_mm;
        int  prev_hold;
        en_cnt = 0; mm_cnt = 0; mm_bad = 0; fs_n = 0; done_cyc = -1; done_n = 0;
        freeze_bad = 0; en_bad = 0; max_cnt = 0; max_fidx = 0; ready_after = 0;
        prev_cnt = 0; prev_mm = 0; prev_hold = 0;
        for (int i = 0; i < 4; i++) begin fs_cyc[i] = -1; fs_fidx[i] = -1; end
        bus.num_frames = 4'(n);
        bus.start = 1'b1;
        bus.hold = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            bus.hold  = ((c >= hs1) && (c < hs1 + hl1)) || ((c >= hs2) && (c < hs2 + hl2));
            bus.start = (c == sp_at);
            #1;
            if (bus.en) en_cnt++;
            if (bus.en !== (bus.busy & ~bus.hold)) en_bad++;
            if (bus.mat_mult_rst && bus.busy) begin
                mm_cnt++;
                if (bus.count != 8'd5) mm_bad++;
            end
            if (bus.frame_start) begin
                if (fs_n < 4) begin fs_cyc[fs_n] = c; fs_fidx[fs_n] = int'(bus.frame_idx); end
                fs_n++;
            end
            if ((prev_hold != 0) && bus.busy &&
                ((int'(bus.count) != prev_cnt) || (int'(bus.mat_mult_rst) != prev_mm)))
                freeze_bad++;
            if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
            if (int'(bus.frame_idx) > max_fidx) max_fidx = int'(bus.frame_idx);
            if (bus.done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = c;
            end
            if ((done_cyc >= 0) && (c == done_cyc + 1)) ready_after = int'(bus.ready);
            prev_cnt  = int'(bus.count);
            prev_mm   = int'(bus.mat_mult_rst);
            prev_hold = int'(bus.hold);
            tick();
        end
        bus.hold = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.start = 1'b1; bus.num_frames = 4'd3; bus.hold = 1'b0;
        repeat (3) tick();
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.en !== 1'b0) begin errors++; $display("FAIL rst_en: got %b want 0", bus.en); end
        checks++; if (bus.mat_mult_rst !== 1'b1) begin errors++; $display("FAIL rst_mm: got %b want 1", bus.mat_mult_rst); end
        checks++; if (bus.array_mult_rst !== 1'b1) begin errors++; $display("FAIL rst_am: got %b want 1", bus.array_mult_rst); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus.done); end
        checks++; if (bus.count !== 8'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", bus.count); end
        checks++; if (bus.frame_idx !== 4'd0) begin errors++; $display("FAIL rst_fidx: got %0d want 0", bus.frame_idx); end
        checks++; if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL rst_fs: got %b want 0", bus.frame_start); end
        bus.start = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        run_job(1, 105, 1000, 0, 1000, 0, -1);
        checks++; if (en_cnt != 99) begin errors++; $display("FAIL single_en_cycles: got %0d want 99", en_cnt); end
        checks++; if (done_cyc != 99) begin errors++; $display("FAIL single_done_cycle: got %0d want 99", done_cyc); end
        checks++; if (done_n != 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", done_n); end
        checks++; if (ready_after != 1) begin errors++; $display("FAIL single_ready_after: got %0d want 1", ready_after); end
        checks++; if (mm_cnt != 1) begin errors++; $display("FAIL single_mm_pulses: got %0d want 1", mm_cnt); end
        checks++; if (mm_bad != 0) begin errors++; $display("FAIL single_mm_pos: got %0d want 0", mm_bad); end
        checks++; if (max_cnt != 90) begin errors++; $display("FAIL single_max_count: got %0d want 90", max_cnt); end
        checks++; if (en_bad != 0) begin errors++; $display("FAIL single_en_rule: got %0d want 0", en_bad); end
        checks++; if (bus.count !== 8'd0) begin errors++; $display("FAIL single_count_end: got %0d want 0", bus.count); end
    endtask

    task automatic test_three_frames();
        run_job(3, 290, 1000, 0, 1000, 0, -1);
        checks++; if (fs_n != 3) begin errors++; $display("FAIL three_fs_count: got %0d want 3", fs_n); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (fs_cyc[k] != 91 * k) begin errors++; $display("FAIL three_fs_cycle%0d: got %0d want %0d", k, fs_cyc[k], 91 * k); end
            checks++; if (fs_fidx[k] != k) begin errors++; $display("FAIL three_fidx%0d: got %0d want %0d", k, fs_fidx[k], k); end
        end
        checks++; if (mm_cnt != 3) begin errors++; $display("FAIL three_mm_pulses: got %0d want 3", mm_cnt); end
        checks++; if (mm_bad != 0) begin errors++; $display("FAIL three_mm_pos: got %0d want 0", mm_bad); end
        checks++; if (done_cyc != 281) begin errors++; $display("FAIL three_done_cycle: got %0d want 281", done_cyc); end
        checks++; if (max_fidx != 2) begin errors++; $display("FAIL three_max_fidx: got %0d want 2", max_fidx); end
    endtask

    task automatic test_hold();
        // 10 held cycles at count 40, then 3 held cycles on the count==90 wrap
        run_job(2, 210, 40, 10, 100, 3, -1);
        checks++; if (done_cyc != 203) begin errors++; $display("FAIL hold_done_cycle: got %0d want 203", done_cyc); end
        checks++; if (fs_cyc[1] != 104) begin errors++; $display("FAIL hold_wrap_cycle: got %0d want 104", fs_cyc[1]); end
        checks++; if (freeze_bad != 0) begin errors++; $display("FAIL hold_freeze: got %0d want 0", freeze_bad); end
        checks++; if (en_bad != 0) begin errors++; $display("FAIL hold_en_rule: got %0d want 0", en_bad); end
        checks++; if (en_cnt != 190) begin errors++; $display("FAIL hold_en_cycles: got %0d want 190", en_cnt); end
        checks++; if (mm_cnt != 2) begin errors++; $display("FAIL hold_mm_pulses: got %0d want 2", mm_cnt); end
    endtask

    task automatic test_ignored_starts();
        int bad;
        bad = 0;
        bus.num_frames = 4'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if ((bus.ready !== 1'b1) || (bus.en !== 1'b0) || (bus.done !== 1'b0) || (bus.busy !== 1'b0)) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL zero_frames_ignored: got %0d bad cycles want 0", bad); end
        run_job(2, 200, 1000, 0, 1000, 0, 50);
        checks++; if (done_n != 1) begin errors++; $display("FAIL busy_start_done_count: got %0d want 1", done_n); end
        checks++; if (done_cyc != 190) begin errors++; $display("FAIL busy_start_done_cycle: got %0d want 190", done_cyc); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_start_not_queued: got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid_run();
        bus.num_frames = 4'd2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (141) tick();
        checks++; if ((bus.count !== 8'd50) || (bus.frame_idx !== 4'd1)) begin
            errors++; $display("FAIL midrst_position: got count %0d fidx %0d want 50/1", bus.count, bus.frame_idx);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", bus.ready); end
        checks++; if (bus.count !== 8'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", bus.count); end
        checks++; if (bus.frame_idx !== 4'd0) begin errors++; $display("FAIL midrst_fidx: got %0d want 0", bus.frame_idx); end
        checks++; if (bus.en !== 1'b0) begin errors++; $display("FAIL midrst_en: got %b want 0", bus.en); end
        checks++; if (bus.mat_mult_rst !== 1'b1) begin errors++; $display("FAIL midrst_mm: got %b want 1", bus.mat_mult_rst); end
        checks++; if (bus.array_mult_rst !== 1'b1) begin errors++; $display("FAIL midrst_am: got %b want 1", bus.array_mult_rst); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", bus.done); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done_late: got %b want 0", bus.done); end
        run_job(1, 105, 1000, 0, 1000, 0, -1);
        checks++; if (done_cyc != 99) begin errors++; $display("FAIL midrst_restart_done: got %0d want 99", done_cyc); end
    endtask

    task automatic test_back_to_back();
        int dn;
        int d0;
        int d1;
        int rdy100;
        int busy101;
        dn = 0; d0 = -1; d1 = -1; rdy100 = -1; busy101 = -1;
        bus.num_frames = 4'd1;
        bus.start = 1'b1;
        tick();
        for (int c = 0; c < 206; c++) begin
            if (bus.done) begin
                if (dn == 0) d0 = c;
                else if (dn == 1) d1 = c;
                dn++;
            end
            if (c == 100) rdy100 = int'(bus.ready);
            if (c == 101) busy101 = int'(bus.busy);
            tick();
        end
        bus.start = 1'b0;
        checks++; if (dn != 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", dn); end
        checks++; if (d0 != 99) begin errors++; $display("FAIL b2b_done0: got %0d want 99", d0); end
        checks++; if (d1 != 200) begin errors++; $display("FAIL b2b_done1: got %0d want 200", d1); end
        checks++; if (rdy100 != 1) begin errors++; $display("FAIL b2b_idle_gap: got %0d want 1", rdy100); end
        checks++; if (busy101 != 1) begin errors++; $display("FAIL b2b_second_accept: got %0d want 1", busy101); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.num_frames = 4'd0;
        bus.hold = 1'b0;
        #1;
        test_reset();
        test_single_frame();
        test_three_frames();
        test_hold();
        test_ignored_starts();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
